muldiv_sequencer: RTL
=====================

// Module: muldiv_sequencer
// PURPOSE
//  Iterative multiply/divide unit and its sequencer for the 5-stage MIPS pipeline. Accepts one MULT/MULTU/DIV/DIVU
//  from the EX stage, runs a one-bit-per-cycle shift-add / restoring-divide loop, and writes HI/LO.
//  Stalls PC and IF/ID and bubbles the ID/EX control word while busy. Its stall outputs are ORed with the load-use hazard unit.
// PARAMETERS
//  WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//  clk               in   1      rising-edge clock
//  rst               in   1      synchronous, active-high reset
//  start             in   1      EX-stage mul/div instruction valid this cycle
//  op                in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a                 in   WIDTH  rs operand (multiplicand / dividend)
//  b                 in   WIDTH  rt operand (multiplier / divisor)
//  flush             in   1      cancel in-flight op (exception / mispredict squash)
//  busy              out  1      state != IDLE
//  PCwrite           out  1      0 = hold PC
//  IFIDwrite         out  1      0 = hold IF/ID
//  Controller_Flush  out  1      1 = zero ID/EX control bits (bubble)
//  done              out  1      one-cycle pulse: HI/LO hold new result
//  div_by_zero       out  1      sticky until next accepted start; set on DIV/DIVU with b==0
//  hi                out  WIDTH  HI register (product upper / remainder)
//  lo                out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//  Reset: state=IDLE, hi=lo=0, done=0, div_by_zero=0, busy=0, PCwrite=IFIDwrite=1, Controller_Flush=0.
//  FSM states IDLE, BUSY, DONE:
//   IDLE: start & !flush -> latch |a|,|b| (signed ops: two's-complement magnitude), sign flags, op; count=WIDTH;
//         clear div_by_zero; go BUSY. Divide with b==0 -> go DONE directly instead (no iterations).
//   BUSY: one iteration per cycle, count decrements; on count==1 final sign correction applied and hi/lo
//         registered on that edge; go DONE. flush -> IDLE next cycle, hi/lo/div_by_zero unchanged, no done.
//   DONE: done=1 for exactly this cycle; -> IDLE unconditionally (start in DONE cycle is ignored, not queued).
//  Stall (combinational): stall = (state==IDLE & start & !flush & !div0) | (state==IDLE & start & !flush & div0) | state==BUSY;
//   i.e. stall in start cycle and every BUSY cycle. stall -> PCwrite=0, IFIDwrite=0, Controller_Flush=1; else 1,1,0.
//  Latency: start at cycle N -> BUSY cycles N+1..N+WIDTH -> done at N+WIDTH+1; stall asserted N..N+WIDTH (WIDTH+1 cycles).
//  Divide-by-zero: start at N -> done at N+1, stall only at N; hi=a (raw), lo=all ones, div_by_zero=1.
//  Arithmetic: unsigned core on magnitudes; full 2*WIDTH product, no truncation.
//   MULT: negate 2*WIDTH product if sign(a)!=sign(b).
//   DIV: quotient negated if signs differ; remainder takes dividend sign.
//   Most-negative / -1: lo=0x80000000, hi=0 (wraps; no trap).
//  start while state!=IDLE: ignored. flush & start same cycle in IDLE: flush wins, nothing accepted, no stall.
//  rst mid-operation: immediate return to reset values on that edge; no done pulse.
//  hi/lo change only on the BUSY->DONE edge, the IDLE->DONE (div-by-zero) edge, or rst.
// TESTING
//  1 MULTU a=0xFFFFFFFF b=0xFFFFFFFF start@0 -> PCwrite=0 cycles 0..32, done@33, hi=0xFFFFFFFE lo=0x00000001.
//  2 MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB; DIVU a=100 b=7 -> lo=14 hi=2.
//  3 DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  4 DIVU a=0x1234 b=0 start@0 -> stall only cycle 0, done@1, hi=0x1234 lo=0xFFFFFFFF div_by_zero=1; next start clears it.
//  5 after test 2 result, MULTU 5*6 start@0, flush@10 -> busy=0 @11, no done, hi/lo still 2/14, PCwrite=1 @11.
//  6 rst=1 @15 of a BUSY op -> @16 hi=lo=0, busy=0, PCwrite=1; start @0 with flush=1 -> no stall, busy stays 0.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Bundle between the EX stage and the iterative multiply/divide sequencer:
// request inputs, stall controls, result registers and an FSM state tap.
interface muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             PCwrite;
    logic             IFIDwrite;
    logic             Controller_Flush;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [1:0]       dbg_state;

    // A request is taken only in a cycle where start=1, flush=0 and the unit is idle;
    // there is no ready signal, the pipeline is held through the stall outputs instead.
    modport master (
        output start, op, a, b, flush,
        input  busy, PCwrite, IFIDwrite, Controller_Flush, done, div_by_zero, hi, lo, dbg_state
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, PCwrite, IFIDwrite, Controller_Flush, done, div_by_zero, hi, lo, dbg_state
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU unit: one shift-add or restoring-divide step per cycle
// on operand magnitudes, sign fix-up on the last step, plus pipeline stall generation.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CW-1:0]    r_count;
    logic             r_is_div;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_mb;
    logic [WIDTH-1:0] r_wh;
    logic [WIDTH-1:0] r_wl;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_dz;

    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic             w_accept;
    logic             w_div0;
    logic             w_stall;
    logic             w_last;

    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic [WIDTH-1:0]   w_it_h;
    logic [WIDTH-1:0]   w_it_l;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_n;
    logic [WIDTH-1:0]   w_fin_h;
    logic [WIDTH-1:0]   w_fin_l;

    assign w_is_div = bus.op[1];
    assign w_a_neg  = bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg  = bus.op[0] & bus.b[WIDTH-1];
    assign w_mag_a  = w_a_neg ? (~bus.a + 1'b1) : bus.a;
    assign w_mag_b  = w_b_neg ? (~bus.b + 1'b1) : bus.b;
    assign w_accept = (r_state == S_IDLE) & bus.start & ~bus.flush;
    assign w_div0   = w_is_div & (bus.b == '0);
    assign w_last   = (r_count == CW'(1));

    // Multiply: {r_wh,r_wl} shifts right, multiplier bits consumed from r_wl[0].
    // Divide: {r_wh,r_wl} shifts left, r_wh is the partial remainder, quotient fills r_wl.
    assign w_mul_sum   = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_mb} : '0);
    assign w_div_shift = {r_wh, r_wl[WIDTH-1]};
    assign w_div_diff  = w_div_shift - {1'b0, r_mb};

    always_comb begin
        w_it_h = '0;
        w_it_l = '0;
        if (r_is_div) begin
            if (!w_div_diff[WIDTH]) begin
                w_it_h = w_div_diff[WIDTH-1:0];
                w_it_l = {r_wl[WIDTH-2:0], 1'b1};
            end else begin
                w_it_h = w_div_shift[WIDTH-1:0];
                w_it_l = {r_wl[WIDTH-2:0], 1'b0};
            end
        end else begin
            {w_it_h, w_it_l} = {w_mul_sum, r_wl[WIDTH-1:1]};
        end
    end

    assign w_prod   = {w_it_h, w_it_l};
    assign w_prod_n = ~w_prod + 1'b1;

    // Remainder follows the dividend sign; most-negative / -1 wraps naturally here.
    always_comb begin
        w_fin_h = '0;
        w_fin_l = '0;
        if (r_is_div) begin
            w_fin_l = r_neg_q ? (~w_it_l + 1'b1) : w_it_l;
            w_fin_h = r_neg_r ? (~w_it_h + 1'b1) : w_it_h;
        end else begin
            {w_fin_h, w_fin_l} = r_neg_q ? w_prod_n : w_prod;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_div0 ? S_DONE : S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.flush) begin
                    w_state_next = S_IDLE;
                end else if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_mb     <= '0;
            r_wh     <= '0;
            r_wl     <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_is_div <= w_is_div;
                        r_neg_q  <= w_a_neg ^ w_b_neg;
                        r_neg_r  <= w_a_neg;
                        r_mb     <= w_mag_b;
                        r_wh     <= '0;
                        r_wl     <= w_mag_a;
                        r_count  <= CW'(WIDTH);
                        r_dz     <= w_div0;
                        if (w_div0) begin
                            r_hi <= bus.a;
                            r_lo <= '1;
                        end
                    end
                end
                S_BUSY: begin
                    if (!bus.flush) begin
                        r_wh    <= w_it_h;
                        r_wl    <= w_it_l;
                        r_count <= r_count - CW'(1);
                        if (w_last) begin
                            r_hi <= w_fin_h;
                            r_lo <= w_fin_l;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_stall = w_accept | (r_state == S_BUSY);

    assign bus.busy             = (r_state != S_IDLE);
    assign bus.PCwrite          = ~w_stall;
    assign bus.IFIDwrite        = ~w_stall;
    assign bus.Controller_Flush = w_stall;
    assign bus.done             = (r_state == S_DONE);
    assign bus.div_by_zero      = r_dz;
    assign bus.hi               = r_hi;
    assign bus.lo               = r_lo;
    assign bus.dbg_state        = r_state;
endmodule
